lsu_queue: RTL and testbench

- Parametrised load/store unit for the Tomasulo core; replaces the single-entry memory stage.
- Buffers up to DEPTH memory operations in program order and computes effective address base+offset.
- Issues operations one at a time to an external RAM port with a done handshake.
- Broadcasts load results with their RS tag over a CDB request/grant handshake; stores retire silently.

---
 rtl/lsu_queue.sv | 100 ++++++++++
 tb/tb_lsu_queue.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_queue.sv
// lsu_queue: in-order load/store queue that issues one access at a time to a RAM port
// and broadcasts load results with their RS tag over the CDB.
module lsu_queue #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int TAG_W = 4,
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_op,
    input  logic [DATA_W-1:0] in_base,
    input  logic [DATA_W-1:0] in_offset,
    input  logic [DATA_W-1:0] in_wdata,
    input  logic [TAG_W-1:0]  in_tag,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_done,
    output logic              cdb_req,
    output logic [TAG_W-1:0]  cdb_tag,
    output logic [DATA_W-1:0] cdb_data,
    input  logic              cdb_grant,
    output logic [CNT_W-1:0]  count
);
    localparam int PTR_W = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, BCAST} state_t;

    state_t            state, stateNext;
    logic [PTR_W-1:0]  wrPtr, rdPtr;
    logic              opQ    [DEPTH];
    logic [ADDR_W-1:0] addrQ  [DEPTH];
    logic [DATA_W-1:0] wdataQ [DEPTH];
    logic [TAG_W-1:0]  tagQ   [DEPTH];
    logic [ADDR_W-1:0] addrHold;
    logic [DATA_W-1:0] wdataHold;
    logic              push, pop;
    logic [CNT_W-1:0]  countNext;

    assign in_ready  = count != CNT_W'(DEPTH);
    assign push      = in_valid && in_ready;
    assign pop       = (state == WAIT && mem_done && !opQ[rdPtr]) || (state == BCAST && cdb_grant);
    assign countNext = count + CNT_W'(push) - CNT_W'(pop);

    assign mem_rd    = state == ISSUE && opQ[rdPtr];
    assign mem_wr    = state == ISSUE && !opQ[rdPtr];
    assign mem_addr  = state == ISSUE ? addrQ[rdPtr] : addrHold;
    assign mem_wdata = state == ISSUE ? wdataQ[rdPtr] : wdataHold;
    assign cdb_req   = state == BCAST;

    // A pop always hands over to the next entry, including one pushed on the same edge.
    always_comb begin
        stateNext = state == IDLE ? (count != '0 ? ISSUE : IDLE)
                  : state == ISSUE ? WAIT
                  : pop ? (countNext != '0 ? ISSUE : IDLE)
                  : state == WAIT && mem_done ? BCAST
                  : state;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            wrPtr     <= '0;
            rdPtr     <= '0;
            count     <= '0;
            addrHold  <= '0;
            wdataHold <= '0;
            cdb_tag   <= '0;
            cdb_data  <= '0;
        end else begin
            state <= stateNext;
            count <= countNext;
            if (push) wrPtr <= wrPtr + PTR_W'(1);
            if (pop) rdPtr <= rdPtr + PTR_W'(1);
            if (state == ISSUE) begin
                addrHold  <= addrQ[rdPtr];
                wdataHold <= wdataQ[rdPtr];
            end
            if (state == WAIT && mem_done && opQ[rdPtr]) begin
                cdb_tag  <= tagQ[rdPtr];
                cdb_data <= mem_rdata;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && push) begin
            opQ[wrPtr]    <= in_op;
            addrQ[wrPtr]  <= ADDR_W'(in_base + in_offset);
            wdataQ[wrPtr] <= in_wdata;
            tagQ[wrPtr]   <= in_tag;
        end
    end
endmodule

// File: tb/tb_lsu_queue.sv
// tb_lsu_queue: directed scenarios plus random traffic for lsu_queue, checked against
// an in-order queue/memory reference model and a behavioural RAM/CDB environment.
module tb_lsu_queue;
    localparam int DEPTH = 4;

    typedef struct {logic op; logic [31:0] base, offset, wdata; logic [3:0] tag;} disp_t;
    typedef struct {logic op; logic [31:0] addr, wdata;} acc_t;
    typedef struct {logic [3:0] tag; logic [31:0] data;} res_t;

    logic        clk = 0, rst_n = 0;
    logic        in_valid = 0, in_ready, in_op = 0;
    logic [31:0] in_base = 0, in_offset = 0, in_wdata = 0;
    logic [3:0]  in_tag = 0;
    logic        mem_rd, mem_wr, mem_done = 0, cdb_req, cdb_grant = 0;
    logic [31:0] mem_addr, mem_wdata, mem_rdata = 0, cdb_data;
    logic [3:0]  cdb_tag;
    logic [2:0]  count;

    disp_t       dispQ[$];
    acc_t        accQ[$];
    res_t        resQ[$];
    logic [31:0] refMem[logic [31:0]];
    logic [31:0] envMem[logic [31:0]];
    int          checks = 0, errors = 0, modelCount = 0, delay = 0, fixDelay = -1;
    int          grantPct = 100, pushPct = 0, nBcast = 0;
    bit          pending = 0, pendOp = 0, loadDone = 0, memStall = 0, randomIn = 0;
    logic [31:0] pendAddr = 0, pendWdata = 0, lastData = 0;

    lsu_queue #(.DATA_W(32), .ADDR_W(32), .TAG_W(4), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_base(in_base), .in_offset(in_offset), .in_wdata(in_wdata), .in_tag(in_tag),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_done(mem_done), .cdb_req(cdb_req), .cdb_tag(cdb_tag),
        .cdb_data(cdb_data), .cdb_grant(cdb_grant), .count(count)
    );

    always #5 clk = ~clk;

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] initVal(logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    function automatic logic [31:0] refRead(logic [31:0] a);
        return refMem.exists(a) ? refMem[a] : initVal(a);
    endfunction

    function automatic logic [31:0] envRead(logic [31:0] a);
        return envMem.exists(a) ? envMem[a] : initVal(a);
    endfunction

    task automatic addDisp(logic op, logic [31:0] base, logic [31:0] offset, logic [31:0] wdata, logic [3:0] tag);
        disp_t d;
        d.op = op; d.base = base; d.offset = offset; d.wdata = wdata; d.tag = tag;
        dispQ.push_back(d);
    endtask

    // One clock cycle: check outputs at the negedge, play RAM/CDB/dispatch, update the model.
    task automatic tick();
        logic strobe, push, pop, inBcast;
        acc_t a;
        res_t r;
        pop = 0;
        check("count", 32'(count), modelCount);
        check("in_ready", in_ready, modelCount != DEPTH);
        strobe = mem_rd | mem_wr;
        if (strobe) begin
            check("strobe_busy", pending | loadDone, 0);
            if (accQ.size() == 0) check("strobe_unexpected", strobe, 0);
            else begin
                a = accQ.pop_front();
                check("strobe_op", mem_rd, a.op);
                check("strobe_excl", mem_rd & mem_wr, 0);
                check("mem_addr", mem_addr, a.addr);
                if (!a.op) check("mem_wdata", mem_wdata, a.wdata);
                pending = 1; pendOp = a.op; pendAddr = a.addr; pendWdata = a.wdata;
                delay = fixDelay >= 0 ? fixDelay : $urandom_range(0, 3);
            end
        end else if (pending) begin
            check("addr_hold", mem_addr, pendAddr);
            if (!pendOp) check("wdata_hold", mem_wdata, pendWdata);
        end
        check("cdb_req", cdb_req, loadDone);
        if (loadDone && resQ.size() > 0) begin
            check("cdb_tag", cdb_tag, resQ[0].tag);
            check("cdb_data", cdb_data, resQ[0].data);
        end
        inBcast = loadDone && cdb_req && resQ.size() > 0;
        mem_done = 0;
        mem_rdata = $urandom;
        if (pending && !strobe && !memStall) begin
            if (delay == 0) begin
                mem_done = 1;
                pending = 0;
                if (pendOp) begin
                    mem_rdata = envRead(pendAddr);
                    loadDone = 1;
                end else begin
                    envMem[pendAddr] = pendWdata;
                    pop = 1;
                end
            end else delay--;
        end else if (!pending && !strobe && $urandom_range(0, 7) == 0) mem_done = 1;
        cdb_grant = 0;
        if (inBcast) begin
            if ($urandom_range(0, 99) < grantPct) begin
                cdb_grant = 1;
                loadDone = 0;
                pop = 1;
                lastData = cdb_data;
                void'(resQ.pop_front());
                nBcast++;
            end
        end else cdb_grant = $urandom_range(0, 7) == 0;
        in_valid = 0;
        in_op = 1'($urandom); in_base = $urandom; in_offset = $urandom;
        in_wdata = $urandom; in_tag = 4'($urandom);
        if (dispQ.size() > 0) begin
            in_valid = 1; in_op = dispQ[0].op; in_base = dispQ[0].base;
            in_offset = dispQ[0].offset; in_wdata = dispQ[0].wdata; in_tag = dispQ[0].tag;
        end else if (randomIn && $urandom_range(0, 99) < pushPct) begin
            in_valid = 1;
            in_offset = 32'($urandom_range(0, 15)) * 32'd4 - in_base;
        end
        push = in_valid && modelCount != DEPTH;
        if (push && dispQ.size() > 0) void'(dispQ.pop_front());
        @(posedge clk);
        if (push) begin
            a.op = in_op; a.addr = in_base + in_offset; a.wdata = in_wdata;
            accQ.push_back(a);
            if (in_op) begin
                r.tag = in_tag; r.data = refRead(a.addr);
                resQ.push_back(r);
            end else refMem[a.addr] = in_wdata;
        end
        modelCount += int'(push) - int'(pop);
        @(negedge clk);
    endtask

    task automatic drain(int limit);
        int n = 0;
        while ((modelCount != 0 || dispQ.size() != 0 || pending || loadDone) && n < limit) begin
            tick();
            n++;
        end
        check("drain_done", modelCount, 0);
        tick();
    endtask

    initial begin
        int b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_count", 32'(count), 0);
        check("rst_ready", in_ready, 1);
        check("rst_rd", mem_rd, 0);
        check("rst_wr", mem_wr, 0);
        check("rst_req", cdb_req, 0);
        check("rst_addr", mem_addr, 0);
        check("rst_wdata", mem_wdata, 0);
        check("rst_tag", cdb_tag, 0);
        check("rst_data", cdb_data, 0);
        rst_n = 1;

        // single load with exact latency and a held broadcast
        envMem[32'h14] = 32'hDEAD_BEEF;
        refMem[32'h14] = 32'hDEAD_BEEF;
        addDisp(1, 32'h10, 32'h4, 0, 3);
        fixDelay = 1;
        grantPct = 0;
        tick();
        check("lat_c1_rd", mem_rd, 0);
        tick();
        check("lat_c2_rd", mem_rd, 1);
        check("load_addr", mem_addr, 32'h14);
        repeat (3) tick();
        check("load_req", cdb_req, 1);
        check("load_tag", cdb_tag, 3);
        check("load_data", cdb_data, 32'hDEAD_BEEF);
        repeat (2) tick();
        check("load_req_held", cdb_req, 1);
        grantPct = 100;
        tick();
        check("load_req_fall", cdb_req, 0);
        check("load_count", 32'(count), 0);
        fixDelay = -1;

        // store then load to the same address
        addDisp(0, 32'h20, 32'h0, 32'hA5A5_A5A5, 5);
        addDisp(1, 32'h18, 32'h8, 0, 6);
        b0 = nBcast;
        drain(200);
        check("st_ld_bcasts", nBcast - b0, 1);
        check("st_ld_data", lastData, 32'hA5A5_A5A5);

        // fill with memory stalled
        memStall = 1;
        fixDelay = 0;
        for (int i = 0; i < 5; i++) addDisp(0, 32'h40, 32'(i * 4), 32'(i + 100), 4'(i));
        repeat (5) tick();
        check("fill_ready", in_ready, 0);
        check("fill_count", 32'(count), 4);
        memStall = 0;
        for (int n = 0; n < 20 && !in_ready; n++) tick();
        check("fill_ready_again", in_ready, 1);
        drain(200);
        fixDelay = -1;

        // address wrap
        addDisp(0, 32'hFFFF_FFFC, 32'h8, 32'h77, 7);
        for (int n = 0; n < 10 && !mem_wr; n++) tick();
        check("wrap_strobe", mem_wr, 1);
        check("wrap_addr", mem_addr, 32'h4);
        drain(100);

        // reset while an access is outstanding
        memStall = 1;
        for (int i = 0; i < 3; i++) addDisp(1, 32'h80, 32'(i * 4), 0, 4'(8 + i));
        repeat (3) tick();
        check("pre_rst_count", 32'(count), 3);
        rst_n = 0; in_valid = 0; mem_done = 0; cdb_grant = 0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1; mem_done = 1; mem_rdata = 32'hBAD0_BAD0;
        accQ.delete(); resQ.delete();
        pending = 0; loadDone = 0; modelCount = 0; memStall = 0;
        refMem = envMem;
        @(posedge clk);
        @(negedge clk);
        mem_done = 0;
        check("rst2_count", 32'(count), 0);
        check("rst2_req", cdb_req, 0);
        check("rst2_rd", mem_rd, 0);
        check("rst2_wr", mem_wr, 0);
        repeat (4) tick();

        // alternating store/load through several pointer wraps
        for (int i = 0; i < 10; i++)
            addDisp(1'(i % 2), 32'h100, 32'((i / 2) * 4), 32'(32'hC0DE_0000 + i), 4'(i));
        b0 = nBcast;
        drain(300);
        check("ptr_wrap_bcasts", nBcast - b0, 5);
        check("ptr_wrap_count", 32'(count), 0);

        // random traffic
        randomIn = 1;
        pushPct = 60;
        grantPct = 50;
        repeat (3000) tick();
        randomIn = 0;
        drain(1000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
